ram_write_controller: RTL and testbench
=======================================

// Module: ram_write_controller
// PURPOSE
//  Write-side counterpart of the NTT RAM read sweep.
//  Accepts a stream of coefficient pairs over a valid/ready handshake.
//  Writes each pair to the banked coefficient RAMs at the even/odd addresses
//  {pair_idx,0} and {pair_idx,1}. Drives a one-hot bank enable derived from
//  the high pair-index bits.
//  Pulses done once the full polynomial is written. Sits between the NTT
//  output stage and the result RAM banks.
// PARAMETERS
//  DATA_W     16   coefficient width (bits)
//  NUM_PAIRS  256  coefficient pairs per polynomial (power of 2)
//  NUM_BANKS  4    RAM banks (power of 2, <= NUM_PAIRS); bank = pair_idx / (NUM_PAIRS/NUM_BANKS)
// PORTS
//  clk         in   1                         clock, all logic on posedge
//  reset       in   1                         synchronous, active-high reset
//  start       in   1                         begin a polynomial write (honoured in IDLE only)
//  in_valid    in   1                         upstream pair valid
//  in_ready    out  1                         controller can accept a pair
//  in_a        in   DATA_W                    even coefficient
//  in_b        in   DATA_W                    odd coefficient
//  wr_en       out  1                         write strobe, both ports
//  wr_addr_a   out  $clog2(NUM_PAIRS)+1       {pair_idx,1'b0}
//  wr_addr_b   out  $clog2(NUM_PAIRS)+1       {pair_idx,1'b1}
//  wr_data_a   out  DATA_W                    data for wr_addr_a
//  wr_data_b   out  DATA_W                    data for wr_addr_b
//  wr_bank_en  out  NUM_BANKS                 one-hot bank select, valid with wr_en
//  wr_bank_sel out  $clog2(NUM_BANKS)         binary bank index (0 when NUM_BANKS==1)
//  busy        out  1                         state != IDLE
//  done        out  1                         one-cycle pulse, all pairs written
// BEHAVIOUR
//  - Reset values:
//    - All outputs are 0.
//    - The FSM is in IDLE and pair_idx = 0.
//    - Reset mid-operation abandons the sweep.
//    - No done pulse is generated for an abandoned sweep.
//  - FSM states: IDLE, WRITE, DRAIN, DONE.
//    - IDLE -> WRITE on start. pair_idx <= 0.
//    - WRITE -> DRAIN on accepting pair NUM_PAIRS-1.
//    - DRAIN -> DONE unconditionally.
//    - DONE -> IDLE unconditionally.
//  - Handshake:
//    - in_ready = (state==WRITE), combinational from state.
//    - A pair is accepted when in_valid && in_ready.
//    - in_valid outside WRITE is ignored. No write occurs.
//    - start outside IDLE is ignored. This includes start in the DONE cycle.
//  - Latency: a pair accepted at cycle t has its write fields registered at t+1.
//    - At t+1: wr_en=1, wr_addr_a={idx,0}, wr_addr_b={idx,1}.
//    - At t+1: wr_data_a=in_a, wr_data_b=in_b.
//    - At t+1: wr_bank_en = 1 << idx[MSBs], wr_bank_sel = idx[MSBs].
//  - wr_en=0 in any cycle following a non-accept.
//    - Address and data outputs hold their last values.
//    - wr_bank_en is 0 whenever wr_en=0.
//  - pair_idx increments by 1 per accept. It never wraps within a sweep.
//    - On the last accept it returns to 0.
//  - Timing of the final write and done, with the last accept at cycle t:
//    - Final write at t+1 (state DRAIN).
//    - done=1 at t+2 only (state DONE).
//    - busy falls at t+3.
//  - Back-to-back: start asserted at t+3 opens a new sweep.
//    - in_ready rises at t+4.
//  - Throughput: one pair per cycle with in_valid held high.
//    - Gaps in in_valid insert wr_en=0 cycles. Ordering is preserved.
// STRUCTURE
//  - Package ntt_ram_pkg holds:
//    - typedef enum logic [1:0] {IDLE,WRITE,DRAIN,DONE} wr_state_t
//    - localparams PAIR_W=$clog2(NUM_PAIRS), BANK_W=$clog2(NUM_BANKS),
//      PAIRS_PER_BANK=NUM_PAIRS/NUM_BANKS.
//  - One sub-module: ram_bank_decoder.
//    - Converts the binary bank index to one-hot, gated by an enable.
//    - Pure combinational. The read controller reuses it.
// TESTING
//  1. reset, start, in_valid=1 for 256 cycles with in_a=2k, in_b=2k+1:
//     - first write: addr 0/1, data 0/1, bank_en 4'b0001, one cycle after the first accept.
//     - pair 64: addr 128/129, bank_en 4'b0010.
//     - pair 255: addr 510/511, bank_en 4'b1000.
//     - done high exactly 2 cycles after the 256th accept, for 1 cycle.
//  2. in_valid toggled 1,0,0,1 during WRITE:
//     - wr_en pattern 1,0,0,1 one cycle later.
//     - wr_bank_en is 0 on gap cycles.
//     - addresses are contiguous, with no skipped or duplicated pair_idx.
//  3. in_valid=1 in IDLE, no start:
//     - in_ready=0, wr_en stays 0, busy=0, pair_idx unchanged.
//  4. start pulsed at pair 10 mid-sweep and again in the DONE cycle:
//     - both are ignored.
//     - addressing continues from pair 11.
//     - exactly one done pulse.
//  5. reset asserted at pair 100, then start:
//     - all outputs 0 the cycle after reset.
//     - no done pulse.
//     - the new sweep's first write is at addr 0/1.
//  6. NUM_BANKS=1, NUM_PAIRS=8 instance:
//     - wr_bank_en = 1'b1 on every write.
//     - done after 8 accepts + 2 cycles.

Source files
------------

// File: rtl/ntt_ram_pkg.sv
// Shared types and sizing for the NTT coefficient RAM read/write controllers.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
package ntt_ram_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WRITE = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } wr_state_t;

    // Default polynomial geometry.
    localparam int unsigned DATA_W_DEF    = 16;
    localparam int unsigned NUM_PAIRS_DEF = 256;
    localparam int unsigned NUM_BANKS_DEF = 4;

    localparam int unsigned PAIR_W         = $clog2(NUM_PAIRS_DEF);
    localparam int unsigned BANK_W         = $clog2(NUM_BANKS_DEF);
    localparam int unsigned PAIRS_PER_BANK = NUM_PAIRS_DEF / NUM_BANKS_DEF;

    // Bit width of an index over n items, never below 1 so a single-item
    // index still gets a real (constant-zero) port.
    function automatic int unsigned width_min1(input int unsigned n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/ram_bank_decoder.sv
// Binary bank index to one-hot bank enable, gated by en.
// Latency: purely combinational, zero cycles.
// Backpressure: none; output follows inputs every cycle.
//
// Ports:
//   sel      binary bank index
//   en       gate; bank_en is all-zero when low
//   bank_en  one-hot bank enable
module ram_bank_decoder #(
    parameter int unsigned NUM_BANKS = 4,
    parameter int unsigned SEL_W     = 2
) (
    input  logic [SEL_W-1:0]     sel,
    input  logic                 en,
    output logic [NUM_BANKS-1:0] bank_en
);

    always_comb begin
        bank_en = '0;
        for (int i = 0; i < NUM_BANKS; i++) begin
            if (en && (int'(sel) == i)) begin
                bank_en[i] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/ram_write_controller.sv
// Writes a stream of coefficient pairs into banked RAM at {idx,0}/{idx,1}; pulses done after the last pair.
// Latency: a pair accepted in cycle t appears on the write port in cycle t+1; done two cycles after the last accept.
// Backpressure: in_ready is high only in WRITE; upstream must hold in_valid/in_a/in_b until accepted.
//
// Ports:
//   clk, reset                  clock and synchronous active-high reset
//   start                       begin a polynomial (only looked at in IDLE)
//   in_valid/in_ready/in_a/in_b upstream pair handshake
//   wr_en, wr_addr_*, wr_data_* registered write port, both halves of the pair
//   wr_bank_en, wr_bank_sel     bank select, one-hot and binary
//   busy, done                  status: not idle / one-cycle completion pulse
module ram_write_controller
    import ntt_ram_pkg::*;
#(
    parameter int unsigned DATA_W    = DATA_W_DEF,
    parameter int unsigned NUM_PAIRS = NUM_PAIRS_DEF,
    parameter int unsigned NUM_BANKS = NUM_BANKS_DEF
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic                              start,
    input  logic                              in_valid,
    output logic                              in_ready,
    input  logic [DATA_W-1:0]                 in_a,
    input  logic [DATA_W-1:0]                 in_b,
    output logic                              wr_en,
    output logic [$clog2(NUM_PAIRS):0]        wr_addr_a,
    output logic [$clog2(NUM_PAIRS):0]        wr_addr_b,
    output logic [DATA_W-1:0]                 wr_data_a,
    output logic [DATA_W-1:0]                 wr_data_b,
    output logic [NUM_BANKS-1:0]              wr_bank_en,
    output logic [width_min1(NUM_BANKS)-1:0]  wr_bank_sel,
    output logic                              busy,
    output logic                              done
);

    localparam int unsigned IDX_W = $clog2(NUM_PAIRS);
    localparam int unsigned SEL_W = width_min1(NUM_BANKS);

    wr_state_t        state;
    wr_state_t        state_nxt;
    logic [IDX_W-1:0] pair_idx;
    logic [SEL_W-1:0] idx_bank;
    logic             accept;
    logic             last_pair;

    assign accept    = in_valid && in_ready;
    assign last_pair = (pair_idx == IDX_W'(NUM_PAIRS - 1));

    // Banks split the pair space into equal contiguous slices, so the bank
    // is simply the top bits of the pair index.
    generate
        if (NUM_BANKS == 1) begin : g_single_bank
            assign idx_bank = '0;
        end else begin : g_multi_bank
            assign idx_bank = pair_idx[IDX_W-1 -: SEL_W];
        end
    endgenerate

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = WRITE;
            WRITE:   if (accept && last_pair) state_nxt = DRAIN;
            DRAIN:   state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // State-decoded outputs
    always_comb begin
        in_ready = 1'b0;
        busy     = 1'b0;
        done     = 1'b0;
        case (state)
            IDLE:    ;
            WRITE:   begin in_ready = 1'b1; busy = 1'b1; end
            DRAIN:   busy = 1'b1;
            DONE:    begin busy = 1'b1; done = 1'b1; end
            default: ;
        endcase
    end

    // Write port and pair counter. Address/data/bank index hold between
    // accepts; only wr_en (and through it wr_bank_en) drops on gaps.
    always_ff @(posedge clk) begin
        if (reset) begin
            pair_idx    <= '0;
            wr_en       <= 1'b0;
            wr_addr_a   <= '0;
            wr_addr_b   <= '0;
            wr_data_a   <= '0;
            wr_data_b   <= '0;
            wr_bank_sel <= '0;
        end else begin
            wr_en <= accept;
            if ((state == IDLE) && start) begin
                pair_idx <= '0;
            end else if (accept) begin
                pair_idx <= last_pair ? '0 : pair_idx + IDX_W'(1);
            end
            if (accept) begin
                wr_addr_a   <= {pair_idx, 1'b0};
                wr_addr_b   <= {pair_idx, 1'b1};
                wr_data_a   <= in_a;
                wr_data_b   <= in_b;
                wr_bank_sel <= idx_bank;
            end
        end
    end

    // Decoding from the registered index gated by registered wr_en keeps
    // wr_bank_en aligned with the write and zero on gap cycles.
    ram_bank_decoder #(
        .NUM_BANKS (NUM_BANKS),
        .SEL_W     (SEL_W)
    ) u_bank_decoder (
        .sel     (wr_bank_sel),
        .en      (wr_en),
        .bank_en (wr_bank_en)
    );

endmodule

// File: tb/tb_ram_write_controller.sv
module tb_ram_write_controller;
    import ntt_ram_pkg::*;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    // Main instance: 16-bit data, 256 pairs, 4 banks
    logic                      start, in_valid, in_ready;
    logic [DATA_W_DEF-1:0]     in_a, in_b;
    logic                      wr_en;
    logic [PAIR_W:0]           wr_addr_a, wr_addr_b;
    logic [DATA_W_DEF-1:0]     wr_data_a, wr_data_b;
    logic [NUM_BANKS_DEF-1:0]  wr_bank_en;
    logic [BANK_W-1:0]         wr_bank_sel;
    logic                      busy, done;

    // Small instance: 8 pairs, 1 bank
    logic                      s_start, s_in_valid, s_in_ready;
    logic [15:0]               s_in_a, s_in_b;
    logic                      s_wr_en;
    logic [3:0]                s_wr_addr_a, s_wr_addr_b;
    logic [15:0]               s_wr_data_a, s_wr_data_b;
    logic [0:0]                s_wr_bank_en;
    logic [0:0]                s_wr_bank_sel;
    logic                      s_busy, s_done;

    int checks = 0;
    int passes = 0;

    ram_write_controller #(.DATA_W(16), .NUM_PAIRS(256), .NUM_BANKS(4)) dut (
        .clk(clk), .reset(reset), .start(start), .in_valid(in_valid), .in_ready(in_ready),
        .in_a(in_a), .in_b(in_b), .wr_en(wr_en), .wr_addr_a(wr_addr_a), .wr_addr_b(wr_addr_b),
        .wr_data_a(wr_data_a), .wr_data_b(wr_data_b), .wr_bank_en(wr_bank_en),
        .wr_bank_sel(wr_bank_sel), .busy(busy), .done(done)
    );

    ram_write_controller #(.DATA_W(16), .NUM_PAIRS(8), .NUM_BANKS(1)) dut_small (
        .clk(clk), .reset(reset), .start(s_start), .in_valid(s_in_valid), .in_ready(s_in_ready),
        .in_a(s_in_a), .in_b(s_in_b), .wr_en(s_wr_en), .wr_addr_a(s_wr_addr_a), .wr_addr_b(s_wr_addr_b),
        .wr_data_a(s_wr_data_a), .wr_data_b(s_wr_data_b), .wr_bank_en(s_wr_bank_en),
        .wr_bank_sel(s_wr_bank_sel), .busy(s_busy), .done(s_done)
    );

    // {wr_en, addr_a, addr_b, data_a, data_b, bank_en, bank_sel}
    function automatic logic [56:0] wr_fields();
        return {wr_en, wr_addr_a, wr_addr_b, wr_data_a, wr_data_b, wr_bank_en, wr_bank_sel};
    endfunction

    function automatic logic [42:0] s_fields();
        return {s_wr_en, s_wr_addr_a, s_wr_addr_b, s_wr_data_a, s_wr_data_b, s_wr_bank_en, s_wr_bank_sel};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        reset = 1'b1;
        start = 1'b0; in_valid = 1'b0; in_a = '0; in_b = '0;
        s_start = 1'b0; s_in_valid = 1'b0; s_in_a = '0; s_in_b = '0;
        step();
        step();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        apply_reset();
        reset = 1'b1;
        step();
        checks++;
        if ({in_ready, busy, done, wr_fields()} !== 60'd0) begin
            $display("FAIL reset_main got %h exp 0", {in_ready, busy, done, wr_fields()});
        end else passes++;
        checks++;
        if ({s_in_ready, s_busy, s_done, s_fields()} !== 46'd0) begin
            $display("FAIL reset_small got %h exp 0", {s_in_ready, s_busy, s_done, s_fields()});
        end else passes++;
        reset = 1'b0;
    endtask

    // Full 256-pair sweep with in_a=2k, in_b=2k+1, then a back-to-back start.
    task automatic test_full_sweep();
        int err = 0;
        apply_reset();
        start = 1'b1;
        step();
        start = 1'b0;
        checks++;
        if ({busy, in_ready} !== 2'b11) begin
            $display("FAIL sweep_enter_write got %b exp 11", {busy, in_ready});
        end else passes++;
        for (int k = 0; k < 256; k++) begin
            in_valid = 1'b1;
            in_a = 16'(2 * k);
            in_b = 16'(2 * k + 1);
            step();
            if (wr_fields() !== {1'b1, 9'(2 * k), 9'(2 * k + 1), 16'(2 * k), 16'(2 * k + 1),
                                 4'(1 << (k / PAIRS_PER_BANK)), 2'(k / PAIRS_PER_BANK)} || done !== 1'b0)
                err++;
            if (k == 0) begin
                checks++;
                if (wr_fields() !== {1'b1, 9'd0, 9'd1, 16'd0, 16'd1, 4'b0001, 2'd0}) begin
                    $display("FAIL first_write got %h exp %h", wr_fields(),
                             {1'b1, 9'd0, 9'd1, 16'd0, 16'd1, 4'b0001, 2'd0});
                end else passes++;
            end
            if (k == 64) begin
                checks++;
                if (wr_fields() !== {1'b1, 9'd128, 9'd129, 16'd128, 16'd129, 4'b0010, 2'd1}) begin
                    $display("FAIL pair64_write got %h exp %h", wr_fields(),
                             {1'b1, 9'd128, 9'd129, 16'd128, 16'd129, 4'b0010, 2'd1});
                end else passes++;
            end
        end
        in_valid = 1'b0;
        // Cycle t+1 after the last accept: final write, state DRAIN
        checks++;
        if ({wr_fields(), busy, done} !== {1'b1, 9'd510, 9'd511, 16'd510, 16'd511, 4'b1000, 2'd3, 1'b1, 1'b0}) begin
            $display("FAIL pair255_write got %h exp %h", {wr_fields(), busy, done},
                     {1'b1, 9'd510, 9'd511, 16'd510, 16'd511, 4'b1000, 2'd3, 1'b1, 1'b0});
        end else passes++;
        checks++;
        if (err != 0) begin
            $display("FAIL sweep_all_writes got %0d bad cycles exp 0", err);
        end else passes++;
        step(); // t+2
        checks++;
        if ({done, busy, wr_en, wr_bank_en, in_ready} !== 8'b1100_0000) begin
            $display("FAIL done_pulse got %b exp 11000000", {done, busy, wr_en, wr_bank_en, in_ready});
        end else passes++;
        step(); // t+3
        checks++;
        if ({done, busy, in_ready} !== 3'b000) begin
            $display("FAIL after_done got %b exp 000", {done, busy, in_ready});
        end else passes++;
        start = 1'b1;
        step(); // t+4
        start = 1'b0;
        checks++;
        if ({in_ready, busy} !== 2'b11) begin
            $display("FAIL back_to_back got %b exp 11", {in_ready, busy});
        end else passes++;
    endtask

    // in_valid pattern 1,0,0,1,1: wr_en follows one cycle later, fields hold on gaps.
    task automatic test_gaps();
        logic pat [5] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
        int p = 0;
        apply_reset();
        start = 1'b1;
        step();
        start = 1'b0;
        for (int i = 0; i < 5; i++) begin
            in_valid = pat[i];
            in_a = 16'(16'h1000 + p);
            in_b = 16'(16'h2000 + p);
            step();
            checks++;
            if (pat[i]) begin
                if (wr_fields() !== {1'b1, 9'(2 * p), 9'(2 * p + 1), 16'(16'h1000 + p), 16'(16'h2000 + p), 4'b0001, 2'd0}) begin
                    $display("FAIL gap_write_%0d got %h exp pair %0d", i, wr_fields(), p);
                end else passes++;
                p++;
            end else begin
                // Previous pair's fields hold, strobe and bank enable are low
                if (wr_fields() !== {1'b0, 9'(2 * p - 2), 9'(2 * p - 1), 16'(16'h1000 + p - 1), 16'(16'h2000 + p - 1), 4'b0000, 2'd0}) begin
                    $display("FAIL gap_idle_%0d got %h exp hold of pair %0d", i, wr_fields(), p - 1);
                end else passes++;
            end
        end
        in_valid = 1'b0;
    endtask

    task automatic test_idle_valid();
        apply_reset();
        in_valid = 1'b1;
        in_a = 16'd55;
        in_b = 16'd66;
        for (int i = 0; i < 4; i++) begin
            step();
            checks++;
            if ({in_ready, wr_en, busy, wr_bank_en} !== 7'd0) begin
                $display("FAIL idle_valid_%0d got %b exp 0", i, {in_ready, wr_en, busy, wr_bank_en});
            end else passes++;
        end
        start = 1'b1;
        step();
        start = 1'b0;
        in_a = 16'd7;
        in_b = 16'd9;
        step();
        in_valid = 1'b0;
        checks++;
        if (wr_fields() !== {1'b1, 9'd0, 9'd1, 16'd7, 16'd9, 4'b0001, 2'd0}) begin
            $display("FAIL idle_then_first got %h exp %h", wr_fields(),
                     {1'b1, 9'd0, 9'd1, 16'd7, 16'd9, 4'b0001, 2'd0});
        end else passes++;
    endtask

    task automatic test_start_ignored();
        int err = 0;
        int dcount = 0;
        apply_reset();
        start = 1'b1;
        step();
        start = 1'b0;
        for (int k = 0; k < 256; k++) begin
            in_valid = 1'b1;
            start = (k == 10);
            in_a = 16'(k + 3000);
            in_b = 16'(k + 5000);
            step();
            dcount += int'(done);
            if ({wr_en, wr_addr_a, wr_addr_b, wr_data_a} !== {1'b1, 9'(2 * k), 9'(2 * k + 1), 16'(k + 3000)})
                err++;
            if (k == 11) begin
                checks++;
                if ({wr_addr_a, wr_addr_b} !== {9'd22, 9'd23}) begin
                    $display("FAIL start_mid_pair11 got %0d/%0d exp 22/23", wr_addr_a, wr_addr_b);
                end else passes++;
            end
        end
        start = 1'b0;
        in_valid = 1'b0;
        checks++;
        if (err != 0) begin
            $display("FAIL start_mid_contiguous got %0d bad writes exp 0", err);
        end else passes++;
        step(); // DONE cycle
        dcount += int'(done);
        checks++;
        if (done !== 1'b1) begin
            $display("FAIL start_mid_done got %b exp 1", done);
        end else passes++;
        start = 1'b1;   // arrives in the DONE cycle
        step();
        start = 1'b0;
        dcount += int'(done);
        for (int i = 0; i < 3; i++) begin
            step();
            dcount += int'(done);
        end
        checks++;
        if ({busy, in_ready} !== 2'b00) begin
            $display("FAIL start_in_done got %b exp 00", {busy, in_ready});
        end else passes++;
        checks++;
        if (dcount != 1) begin
            $display("FAIL done_count got %0d exp 1", dcount);
        end else passes++;
    endtask

    task automatic test_reset_mid();
        int dcount = 0;
        apply_reset();
        start = 1'b1;
        step();
        start = 1'b0;
        for (int k = 0; k < 100; k++) begin
            in_valid = 1'b1;
            in_a = 16'(k);
            in_b = 16'(k + 1);
            step();
        end
        in_a = 16'd100;
        in_b = 16'd101;
        reset = 1'b1;
        step();
        checks++;
        if ({in_ready, busy, done, wr_fields()} !== 60'd0) begin
            $display("FAIL reset_mid_outputs got %h exp 0", {in_ready, busy, done, wr_fields()});
        end else passes++;
        reset = 1'b0;
        in_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            step();
            dcount += int'(done) + int'(busy);
        end
        checks++;
        if (dcount != 0) begin
            $display("FAIL reset_mid_no_done got %0d exp 0", dcount);
        end else passes++;
        start = 1'b1;
        step();
        start = 1'b0;
        in_valid = 1'b1;
        in_a = 16'd3;
        in_b = 16'd4;
        step();
        in_valid = 1'b0;
        checks++;
        if (wr_fields() !== {1'b1, 9'd0, 9'd1, 16'd3, 16'd4, 4'b0001, 2'd0}) begin
            $display("FAIL reset_mid_restart got %h exp %h", wr_fields(),
                     {1'b1, 9'd0, 9'd1, 16'd3, 16'd4, 4'b0001, 2'd0});
        end else passes++;
    endtask

    task automatic test_small();
        apply_reset();
        s_start = 1'b1;
        step();
        s_start = 1'b0;
        for (int k = 0; k < 8; k++) begin
            s_in_valid = 1'b1;
            s_in_a = 16'(k + 256);
            s_in_b = 16'(k + 512);
            step();
            checks++;
            if ({s_fields(), s_done} !== {1'b1, 4'(2 * k), 4'(2 * k + 1), 16'(k + 256), 16'(k + 512), 1'b1, 1'b0, 1'b0}) begin
                $display("FAIL small_write_%0d got %h", k, {s_fields(), s_done});
            end else passes++;
        end
        s_in_valid = 1'b0;
        step();
        checks++;
        if ({s_done, s_busy, s_wr_en, s_wr_bank_en} !== 4'b1100) begin
            $display("FAIL small_done got %b exp 1100", {s_done, s_busy, s_wr_en, s_wr_bank_en});
        end else passes++;
        step();
        checks++;
        if ({s_done, s_busy, s_in_ready} !== 3'b000) begin
            $display("FAIL small_after_done got %b exp 000", {s_done, s_busy, s_in_ready});
        end else passes++;
    endtask

    initial begin
        reset = 1'b1;
        start = 1'b0; in_valid = 1'b0; in_a = '0; in_b = '0;
        s_start = 1'b0; s_in_valid = 1'b0; s_in_a = '0; s_in_b = '0;
        test_reset();
        test_full_sweep();
        test_gaps();
        test_idle_valid();
        test_start_ignored();
        test_reset_mid();
        test_small();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
